rf_1p_fifo_ctrl: RTL and testbench
==================================

Name: rf_1p_fifo_ctrl

Overview:
Initiator-side controller that drives an external single-port register file (low-active cen/wen, 1-cycle registered read) and presents it as a show-ahead FIFO.
- Push and pop use valid/ready handshakes.
- The block arbitrates the single memory port between writes and prefetch reads.
- A 2-entry output buffer hides the memory read latency.
- Used wherever a pipeline stage needs deep buffering backed by an rf_1p macro instead of flops.

Parameters:
DATA_W, 32, word width; must equal the attached RF Word_Width.
ADDR_W, 8, RF address width; DEPTH = 1<<ADDR_W; ADDR_W >= 2 required.

Ports:
clk  input  1  clock.
rst  input  1  synchronous reset, active-high.
wr_val_i  input  1  push request.
wr_rdy_o  output  1  push accepted when wr_val_i && wr_rdy_o.
wr_dat_i  input  DATA_W  push data.
rd_val_o  output  1  head word valid.
rd_rdy_i  input  1  consumer takes the head when rd_val_o && rd_rdy_i (pop_fire).
rd_dat_o  output  DATA_W  head word.
count_o  output  ADDR_W+1  total words held (memory + in-flight + output buffer), max DEPTH+2.
mem_cen_o  output  1  RF chip enable, low active.
mem_wen_o  output  1  RF write enable, low active (0 = write, 1 = read).
mem_addr_o  output  ADDR_W  RF address.
mem_data_o  output  DATA_W  RF write data.
mem_data_i  input  DATA_W  RF read data, valid the cycle after a read is issued.

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- State:
  - wr_ptr, rd_ptr (ADDR_W bits each, wrap DEPTH-1 -> 0).
  - mem_cnt (0..DEPTH): written but not yet read-issued.
  - rd_pend: read issued last cycle, data on mem_data_i this cycle.
  - ob: 2-entry output FIFO, with ob_cnt.
- Reset values:
  - Pointers, mem_cnt, rd_pend, ob_cnt and count_o are 0.
  - rd_val_o = 0; rd_dat_o = 0.
  - While rst is high, mem_cen_o = 1, mem_wen_o = 1, mem_addr_o = 0, mem_data_o = 0, and wr_rdy_o = 0.
- Read issue condition:
  - rd_go = (mem_cnt != 0) && (ob_cnt + rd_pend - pop_fire < 2).
- Arbitration (one access per cycle, read has priority):
  - rd_go: mem_cen_o=0, mem_wen_o=1, mem_addr_o=rd_ptr. Then rd_ptr++, mem_cnt--, rd_pend<=1.
  - Else if wr_val_i && mem_cnt != DEPTH: mem_cen_o=0, mem_wen_o=0, mem_addr_o=wr_ptr, mem_data_o=wr_dat_i. Then wr_ptr++, mem_cnt++.
  - Otherwise mem_cen_o=1.
  - wr_rdy_o = !rst && !rd_go && (mem_cnt != DEPTH).
- Memory outputs are combinational from state and inputs. The rd_rdy_i -> mem_cen_o path is intentional.
- Read data capture:
  - When rd_pend=1, mem_data_i is pushed into ob at the end of that cycle.
  - rd_pend clears unless a new read was issued.
- Simultaneous events:
  - ob capture and pop_fire in the same cycle: ob_cnt is unchanged and the order is preserved.
  - mem_cnt increment and decrement cannot coincide, because there is a single port.
- Output:
  - rd_val_o = (ob_cnt != 0); rd_dat_o = ob head.
  - rd_dat_o is held stable while rd_val_o && !rd_rdy_i.
- Latency: word accepted at cycle t -> RF write at t -> read issued no earlier than t+1 -> rd_val_o high no earlier than t+3.
- Throughput: 1 pop/cycle sustained once the buffer is primed. Writes stall only in cycles where a read is issued.
- Capacity and count:
  - Full when mem_cnt == DEPTH; total capacity is DEPTH+2.
  - count_o = mem_cnt + rd_pend + ob_cnt, registered and updated every cycle.
- Empty: rd_val_o=0 while ob is empty, even if a read is in flight.
- Reset mid-operation: all content is discarded and the next push lands at address 0. RF contents are not cleared (not needed).

Test Plan:
Common setup for all scenarios: DATA_W=8, ADDR_W=2.
1. Reset: hold rst 2 cycles with wr_val_i=1 -> wr_rdy_o=0, mem_cen_o=1, rd_val_o=0, count_o=0 throughout; first cycle after rst shows wr_rdy_o=1.
2. Single word: push 0xA5 at cycle 0, rd_rdy_i=0.
   - Cycle 0: cen=0, wen=0, addr=0.
   - Cycle 1: cen=0, wen=1, addr=0.
   - From cycle 3: rd_val_o=1, rd_dat_o=0xA5, count_o=1.
   - Pop at cycle 4 -> rd_val_o=0, count_o=0.
3. Fill: rd_rdy_i=0, offer 0x01..0x08 every cycle.
   - Exactly 6 words are accepted (0x01..0x06); wr_rdy_o=0 afterwards; count_o=6.
   - Then rd_rdy_i=1 -> output 0x01..0x06 in order, count_o=0, rd_val_o=0.
4. Streaming/wrap: push 0x00..0x13 continuously with rd_rdy_i=1 -> all 20 words out in order, pointers wrap 3->0 five times, count_o never exceeds 6.
5. Backpressure: with 4 words stored, toggle rd_rdy_i 1,0,0,1,1 -> rd_dat_o is unchanged in stalled cycles, no duplicates or drops, order preserved.
6. Reset mid-operation: with 3 words held, pulse rst for 1 cycle -> count_o=0, rd_val_o=0; next push 0x5A writes addr 0 and is popped as 0x5A.

Source files
------------

// File: rtl/rf_1p_fifo_ctrl.sv
// Show-ahead FIFO controller in front of a single-port register file.
// Arbitrates the RF port between pushes and prefetch reads; a 2-entry output buffer hides read latency.
module rf_1p_fifo_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_val_i,
   output logic              wr_rdy_o,
   input  logic [DATA_W-1:0] wr_dat_i,
   output logic              rd_val_o,
   input  logic              rd_rdy_i,
   output logic [DATA_W-1:0] rd_dat_o,
   output logic [ADDR_W:0]   count_o,
   output logic              mem_cen_o,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i
);

   localparam int            CW    = ADDR_W + 1;
   localparam int            DEPTH = 1 << ADDR_W;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CW-1:0]     mem_cnt;
   logic              rd_pend;
   logic [DATA_W-1:0] ob_q [2];
   logic              ob_head;
   logic [1:0]        ob_cnt;

   logic              pop_fire;
   logic              rd_go;
   logic              wr_fire;
   logic [1:0]        ob_cnt_nxt;
   logic [CW-1:0]     mem_cnt_nxt;
   logic [CW-1:0]     count_nxt;

   assign rd_val_o = (ob_cnt != 2'd0);
   assign rd_dat_o = ob_q[ob_head];
   assign pop_fire = rd_val_o && rd_rdy_i;

   // Buffer occupancy after this cycle's capture and pop; prefetch only while a slot stays free.
   assign ob_cnt_nxt = ob_cnt + 2'(rd_pend) - 2'(pop_fire);
   assign rd_go      = !rst && (mem_cnt != '0) && (ob_cnt_nxt < 2'd2);
   assign wr_rdy_o   = !rst && !rd_go && (mem_cnt != FULL);
   assign wr_fire    = wr_val_i && wr_rdy_o;

   assign mem_cnt_nxt = rd_go   ? mem_cnt - CW'(1) :
                        wr_fire ? mem_cnt + CW'(1) : mem_cnt;
   assign count_nxt   = mem_cnt_nxt + CW'(rd_go) + CW'(ob_cnt_nxt);

   always_comb begin
      // NOTE: every output gets a default first so no branch can leave it unassigned and infer a latch.
      mem_cen_o  = 1'b1;
      mem_wen_o  = 1'b1;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (rd_go) begin
         mem_cen_o  = 1'b0;
         mem_addr_o = rd_ptr;
      end else if (wr_fire) begin
         mem_cen_o  = 1'b0;
         mem_wen_o  = 1'b0;
         mem_addr_o = wr_ptr;
         mem_data_o = wr_dat_i;
      end
   end

   // NOTE: non-blocking assignments throughout, so every update below sees the pre-edge state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
         ob_head <= 1'b0;
         ob_cnt  <= 2'd0;
         count_o <= '0;
         // NOTE: the output buffer is two flops and is cleared so rd_dat_o reads 0; the RF array is never cleared.
         ob_q[0] <= '0;
         ob_q[1] <= '0;
      end else begin
         if (rd_go)   rd_ptr <= rd_ptr + ADDR_W'(1);
         if (wr_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
         mem_cnt <= mem_cnt_nxt;
         rd_pend <= rd_go;
         // Capture goes to the tail slot as seen before any pop, which keeps order on capture+pop.
         if (rd_pend) ob_q[ob_head ^ ob_cnt[0]] <= mem_data_i;
         if (pop_fire) ob_head <= ~ob_head;
         ob_cnt  <= ob_cnt_nxt;
         count_o <= count_nxt;
      end
   end

endmodule

// File: tb/tb_rf_1p_fifo_ctrl.sv
// Directed bench for rf_1p_fifo_ctrl with a behavioural single-port RF (1-cycle registered read).
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after posedge.
module tb_rf_1p_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_val_i;
   logic              wr_rdy_o;
   logic [DATA_W-1:0] wr_dat_i;
   logic              rd_val_o;
   logic              rd_rdy_i;
   logic [DATA_W-1:0] rd_dat_o;
   logic [ADDR_W:0]   count_o;
   logic              mem_cen_o;
   logic              mem_wen_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic [DATA_W-1:0] mem_data_i = '0;

   int n_checks = 0;
   int n_fail   = 0;

   rf_1p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_val_i   (wr_val_i),
      .wr_rdy_o   (wr_rdy_o),
      .wr_dat_i   (wr_dat_i),
      .rd_val_o   (rd_val_o),
      .rd_rdy_i   (rd_rdy_i),
      .rd_dat_o   (rd_dat_o),
      .count_o    (count_o),
      .mem_cen_o  (mem_cen_o),
      .mem_wen_o  (mem_wen_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_data_i (mem_data_i)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] rf [4];
   always @(posedge clk) begin
      if (!mem_cen_o) begin
         if (!mem_wen_o) rf[mem_addr_o] <= mem_data_o;
         else            mem_data_i     <= rf[mem_addr_o];
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         wr_val_i = 1'b0;
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; wr_val_i = 1'b0; rd_rdy_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic push_n(input logic [7:0] first, input int n);
      int sent = 0;
      for (int c = 0; c < 40 && sent < n; c++) begin
         @(posedge clk); #1;
         wr_val_i = 1'b1; wr_dat_i = first + 8'(sent); rd_rdy_i = 1'b0;
         #1;
         if (wr_rdy_o) sent++;
      end
      n_checks++;
      if (sent !== n) begin
         n_fail++;
         $display("FAIL push_budget: accepted %0d words, required %0d", sent, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_val_i = 1'b1; wr_dat_i = 8'h33; rd_rdy_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #2;
         n_checks++;
         if (wr_rdy_o !== 1'b0 || mem_cen_o !== 1'b1 || rd_val_o !== 1'b0 ||
             count_o !== 3'd0 || rd_dat_o !== 8'h00 || mem_addr_o !== 2'd0 || mem_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold c%0d: wr_rdy=%b cen=%b rd_val=%b count=%0d dat=%h addr=%0d wdata=%h, required 0 1 0 0 00 0 00",
                     c, wr_rdy_o, mem_cen_o, rd_val_o, count_o, rd_dat_o, mem_addr_o, mem_data_o);
         end
      end
      rst = 1'b0; wr_val_i = 1'b0;
      #1;
      n_checks++;
      if (wr_rdy_o !== 1'b1 || mem_cen_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: wr_rdy=%b cen=%b, required 1 1", wr_rdy_o, mem_cen_o);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      wr_val_i = 1'b1; wr_dat_i = 8'hA5; rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (mem_cen_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_addr_o !== 2'd0 || mem_data_o !== 8'hA5 || wr_rdy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_write: cen=%b wen=%b addr=%0d wdata=%h rdy=%b, required 0 0 0 a5 1",
                  mem_cen_o, mem_wen_o, mem_addr_o, mem_data_o, wr_rdy_o);
      end
      @(posedge clk); #1;
      wr_val_i = 1'b0;
      #1;
      n_checks++;
      if (mem_cen_o !== 1'b0 || mem_wen_o !== 1'b1 || mem_addr_o !== 2'd0 || rd_val_o !== 1'b0 || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL single_read_issue: cen=%b wen=%b addr=%0d rd_val=%b count=%0d, required 0 1 0 0 1",
                  mem_cen_o, mem_wen_o, mem_addr_o, rd_val_o, count_o);
      end
      @(posedge clk); #2;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd1 || mem_cen_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_in_flight: rd_val=%b count=%0d cen=%b, required 0 1 1", rd_val_o, count_o, mem_cen_o);
      end
      @(posedge clk); #2;
      n_checks++;
      if (rd_val_o !== 1'b1 || rd_dat_o !== 8'hA5 || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL single_head: rd_val=%b dat=%h count=%0d, required 1 a5 1", rd_val_o, rd_dat_o, count_o);
      end
      @(posedge clk); #1;
      rd_rdy_i = 1'b1;
      #1;
      @(posedge clk); #1;
      rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd0) begin
         n_fail++;
         $display("FAIL single_pop: rd_val=%b count=%0d, required 0 0", rd_val_o, count_o);
      end
   endtask

   task automatic test_fill();
      logic [9:0] rdy_tab = 10'b0011110101;
      logic [7:0] next = 8'h01;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         wr_val_i = (next <= 8'h08); wr_dat_i = next; rd_rdy_i = 1'b0;
         #1;
         n_checks++;
         if (wr_rdy_o !== rdy_tab[c]) begin
            n_fail++;
            $display("FAIL fill_rdy c%0d: wr_rdy=%b, required %b", c, wr_rdy_o, rdy_tab[c]);
         end
         if (wr_val_i && wr_rdy_o) next++;
      end
      n_checks++;
      if (next !== 8'h07 || count_o !== 3'd6 || wr_rdy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: accepted=%0d count=%0d wr_rdy=%b, required 6 6 0", next - 8'h01, count_o, wr_rdy_o);
      end
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         wr_val_i = 1'b0; rd_rdy_i = 1'b1;
         #1;
         n_checks++;
         if (rd_val_o !== 1'b1 || rd_dat_o !== 8'(i)) begin
            n_fail++;
            $display("FAIL fill_drain #%0d: rd_val=%b dat=%h, required 1 %h", i, rd_val_o, rd_dat_o, 8'(i));
         end
      end
      @(posedge clk); #1;
      rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd0 || wr_rdy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_empty: rd_val=%b count=%0d wr_rdy=%b, required 0 0 1", rd_val_o, count_o, wr_rdy_o);
      end
   endtask

   task automatic test_stream();
      int nw = 0;
      int nr = 0;
      int ri = 0;
      int maxc = 0;
      do_reset();
      for (int c = 0; c < 80 && nr < 20; c++) begin
         @(posedge clk); #1;
         wr_val_i = (nw < 20); wr_dat_i = 8'(nw); rd_rdy_i = 1'b1;
         #1;
         if (int'(count_o) > maxc) maxc = int'(count_o);
         if (!mem_cen_o && mem_wen_o) begin
            n_checks++;
            if (mem_addr_o !== 2'(ri)) begin
               n_fail++;
               $display("FAIL stream_raddr #%0d: addr=%0d, required %0d", ri, mem_addr_o, 2'(ri));
            end
            ri++;
         end
         if (wr_val_i && wr_rdy_o) begin
            n_checks++;
            if (mem_cen_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_addr_o !== 2'(nw) || mem_data_o !== 8'(nw)) begin
               n_fail++;
               $display("FAIL stream_write #%0d: cen=%b wen=%b addr=%0d wdata=%h, required 0 0 %0d %h",
                        nw, mem_cen_o, mem_wen_o, mem_addr_o, mem_data_o, 2'(nw), 8'(nw));
            end
            nw++;
         end
         if (rd_val_o) begin
            n_checks++;
            if (rd_dat_o !== 8'(nr)) begin
               n_fail++;
               $display("FAIL stream_data #%0d: dat=%h, required %h", nr, rd_dat_o, 8'(nr));
            end
            nr++;
         end
      end
      n_checks++;
      if (nr !== 20 || nw !== 20 || ri !== 20) begin
         n_fail++;
         $display("FAIL stream_total: popped=%0d pushed=%0d reads=%0d, required 20 20 20", nr, nw, ri);
      end
      n_checks++;
      if (maxc > 6) begin
         n_fail++;
         $display("FAIL stream_count_max: max count=%0d, required <= 6", maxc);
      end
      @(posedge clk); #1;
      wr_val_i = 1'b0; rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd0) begin
         n_fail++;
         $display("FAIL stream_empty: rd_val=%b count=%0d, required 0 0", rd_val_o, count_o);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] rdy_seq = 6'b111001;
      logic [7:0] exp_dat [6] = '{8'h40, 8'h41, 8'h41, 8'h41, 8'h42, 8'h43};
      push_n(8'h40, 4);
      idle(4);
      n_checks++;
      if (count_o !== 3'd4 || rd_val_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_primed: count=%0d rd_val=%b, required 4 1", count_o, rd_val_o);
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         wr_val_i = 1'b0; rd_rdy_i = rdy_seq[c];
         #1;
         n_checks++;
         if (rd_val_o !== 1'b1 || rd_dat_o !== exp_dat[c]) begin
            n_fail++;
            $display("FAIL bp_head c%0d: rd_val=%b dat=%h, required 1 %h", c, rd_val_o, rd_dat_o, exp_dat[c]);
         end
      end
      @(posedge clk); #1;
      rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd0) begin
         n_fail++;
         $display("FAIL bp_empty: rd_val=%b count=%0d, required 0 0", rd_val_o, count_o);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      push_n(8'h70, 3);
      idle(4);
      n_checks++;
      if (count_o !== 3'd3) begin
         n_fail++;
         $display("FAIL mid_primed: count=%0d, required 3", count_o);
      end
      @(posedge clk); #1;
      rst = 1'b1; wr_val_i = 1'b1; wr_dat_i = 8'hEE;
      #1;
      n_checks++;
      if (mem_cen_o !== 1'b1 || wr_rdy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_in_reset: cen=%b wr_rdy=%b, required 1 0", mem_cen_o, wr_rdy_o);
      end
      @(posedge clk); #1;
      rst = 1'b0; wr_val_i = 1'b0;
      #1;
      n_checks++;
      if (count_o !== 3'd0 || rd_val_o !== 1'b0 || rd_dat_o !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_cleared: count=%0d rd_val=%b dat=%h, required 0 0 00", count_o, rd_val_o, rd_dat_o);
      end
      @(posedge clk); #1;
      wr_val_i = 1'b1; wr_dat_i = 8'h5A;
      #1;
      n_checks++;
      if (mem_cen_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_addr_o !== 2'd0 || wr_rdy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_push_addr: cen=%b wen=%b addr=%0d wr_rdy=%b, required 0 0 0 1",
                  mem_cen_o, mem_wen_o, mem_addr_o, wr_rdy_o);
      end
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         wr_val_i = 1'b0;
         #1;
         seen = rd_val_o;
      end
      n_checks++;
      if (!seen || rd_dat_o !== 8'h5A || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL mid_pop_data: seen=%b dat=%h count=%0d, required 1 5a 1", seen, rd_dat_o, count_o);
      end
      @(posedge clk); #1;
      rd_rdy_i = 1'b1;
      #1;
      @(posedge clk); #1;
      rd_rdy_i = 1'b0;
      #1;
      n_checks++;
      if (rd_val_o !== 1'b0 || count_o !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_empty: rd_val=%b count=%0d, required 0 0", rd_val_o, count_o);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
